// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Holds the sequencer state encoding and the shared-counter width calculation.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } seq_state_t;

    // Width of one counter shared by all timed states; never narrower than one bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchronizer with synchronous active-high clear.
// Also intended for the per-domain reset synchronizers downstream.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses PLL reset, waits for and qualifies lock, then releases sys_rst.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   RESET_PLL | pll_rst asserted for RST_CYCLES cycles
//   WAIT_LOCK | PLL released, waiting for synchronized lock (with timeout)
//   STABLE    | lock seen, qualifying LOCK_STABLE_CYCLES consecutive samples
//   RUN       | clocks good, sys_rst released, ready high
//   FAIL      | retries exhausted, PLL held in reset until relock_req or rst
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES         = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int MAX_RETRIES        = 4,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                               refclk,
    input  logic                               rst,
    input  logic                               pll_locked,
    input  logic                               relock_req,
    output logic                               pll_rst,
    output logic                               sys_rst,
    output logic                               ready,
    output logic                               fail,
    output logic                               lock_lost,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [2:0]                         state_o
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

    seq_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [RW-1:0] retry_nxt, retry_inc;
    logic          lock_lost_nxt;
    logic          restart_cnt;
    logic          timed_state;
    logic          locked_s;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    assign retry_inc = retry_cnt + RW'(1);

    always_comb begin
        state_nxt     = state;
        retry_nxt     = retry_cnt;
        lock_lost_nxt = 1'b0;
        restart_cnt   = 1'b0;
        case (state)
            RESET_PLL: begin
                if (relock_req) begin
                    restart_cnt = 1'b1;
                end else if (cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (relock_req) begin
                    state_nxt = RESET_PLL;
                    retry_nxt = '0;
                end else if (locked_s) begin
                    state_nxt = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_nxt = retry_inc;
                    state_nxt = (retry_inc == RETRY_MAX) ? FAIL : RESET_PLL;
                end
            end
            STABLE: begin
                if (relock_req) begin
                    state_nxt = RESET_PLL;
                    retry_nxt = '0;
                end else if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Lock loss outranks a simultaneous relock request so the pulse is never lost.
                if (!locked_s) begin
                    state_nxt     = RESET_PLL;
                    retry_nxt     = '0;
                    lock_lost_nxt = 1'b1;
                end else if (relock_req) begin
                    state_nxt = RESET_PLL;
                    retry_nxt = '0;
                end
            end
            FAIL: begin
                if (relock_req) begin
                    state_nxt = RESET_PLL;
                    retry_nxt = '0;
                end
            end
            default: begin
                state_nxt = RESET_PLL;
                retry_nxt = '0;
            end
        endcase

        timed_state = (state == RESET_PLL) || (state == WAIT_LOCK) || (state == STABLE);
        if ((state_nxt != state) || restart_cnt || !timed_state) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            pll_rst   <= (state_nxt == RESET_PLL) || (state_nxt == FAIL);
            sys_rst   <= (state_nxt != RUN);
            ready     <= (state_nxt == RUN);
            fail      <= (state_nxt == FAIL);
            lock_lost <= lock_lost_nxt;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with a cycle-level behavioural model and literal checks.
// The model tracks phases with "cycles remaining" budgets and a raw-sample history for lock.
module tb_pll_reset_sequencer;

    localparam int RST = 4;
    localparam int LS  = 8;
    localparam int TO  = 32;
    localparam int MR  = 3;
    localparam int SS  = 2;

    localparam int PH_PLLRST = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_QUAL   = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_DEAD   = 4;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [1:0] retry_cnt;
    logic [2:0] state_o;

    int n_vec = 0;
    int n_err = 0;

    pll_reset_sequencer #(
        .RST_CYCLES        (RST),
        .LOCK_STABLE_CYCLES(LS),
        .LOCK_TIMEOUT      (TO),
        .MAX_RETRIES       (MR),
        .SYNC_STAGES       (SS)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fail       (fail),
        .lock_lost  (lock_lost),
        .retry_cnt  (retry_cnt),
        .state_o    (state_o)
    );

    always #5 refclk = ~refclk;

    // ---------------- behavioural model ----------------
    int  ph = PH_PLLRST;
    int  rst_left, wait_left, qual_left, m_retry;
    bit  m_pulse;
    bit  m_ls;
    bit  mhist [SS];
    bit  mvalid = 1'b0;

    task automatic go_pllrst();
        ph       = PH_PLLRST;
        rst_left = RST;
    endtask

    always @(posedge refclk) begin
        m_ls    = mhist[SS-1];
        m_pulse = 1'b0;
        if (rst) begin
            go_pllrst();
            m_retry = 0;
            for (int i = 0; i < SS; i++) mhist[i] = 1'b0;
        end else begin
            case (ph)
                PH_PLLRST: begin
                    if (relock_req) rst_left = RST;
                    else begin
                        rst_left--;
                        if (rst_left == 0) begin ph = PH_WAIT; wait_left = TO; end
                    end
                end
                PH_WAIT: begin
                    if (relock_req) begin go_pllrst(); m_retry = 0; end
                    else if (m_ls) begin ph = PH_QUAL; qual_left = LS; end
                    else begin
                        wait_left--;
                        if (wait_left == 0) begin
                            m_retry++;
                            if (m_retry == MR) ph = PH_DEAD;
                            else go_pllrst();
                        end
                    end
                end
                PH_QUAL: begin
                    if (relock_req) begin go_pllrst(); m_retry = 0; end
                    else if (!m_ls) begin ph = PH_WAIT; wait_left = TO; end
                    else begin
                        qual_left--;
                        if (qual_left == 0) ph = PH_RUN;
                    end
                end
                PH_RUN: begin
                    if (!m_ls) begin m_pulse = 1'b1; m_retry = 0; go_pllrst(); end
                    else if (relock_req) begin m_retry = 0; go_pllrst(); end
                end
                default: begin
                    if (relock_req) begin m_retry = 0; go_pllrst(); end
                end
            endcase
            for (int i = SS - 1; i > 0; i--) mhist[i] = mhist[i-1];
            mhist[0] = pll_locked;
        end
        mvalid = 1'b1;
    end

    logic [9:0] act_vec, exp_vec;

    always @(negedge refclk) begin
        if (mvalid) begin
            act_vec = {state_o, pll_rst, sys_rst, ready, fail, lock_lost, retry_cnt};
            exp_vec = {3'(ph), (ph == PH_PLLRST || ph == PH_DEAD), (ph != PH_RUN),
                       (ph == PH_RUN), (ph == PH_DEAD), m_pulse, 2'(m_retry)};
            n_vec++;
            if (act_vec !== exp_vec) begin
                n_err++;
                $display("FAIL model_cycle t=%0t got=%b want=%b (state,pll_rst,sys_rst,ready,fail,lock_lost,retry)",
                         $time, act_vec, exp_vec);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic wait_ready(output int k);
        k = 0;
        while (!ready && k < 200) begin
            @(negedge refclk);
            k++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, state_o, 0);
        check({tag, "_pll_rst"}, pll_rst, 1);
        check({tag, "_sys_rst"}, sys_rst, 1);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_lock_lost"}, lock_lost, 0);
        check({tag, "_retry"}, retry_cnt, 0);
    endtask

    logic pr [0:130];
    logic fl [0:130];
    int   rc [0:130];

    initial begin
        int n, k, lp, r, c;
        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (3) @(negedge refclk);
        check_reset_values("reset");

        // 1: normal bring-up
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (pll_rst) n++;
            @(negedge refclk);
        end
        check("t1_pll_rst_edges", n, 4);
        pll_locked = 1'b1;
        wait_ready(k);
        check("t1_ready_latency", k, 11);
        check("t1_sys_rst", sys_rst, 0);
        check("t1_retry", retry_cnt, 0);

        // 5: loss of lock in RUN
        pll_locked = 1'b0;
        k = 0;
        while (!lock_lost && k < 20) begin
            @(negedge refclk);
            k++;
        end
        check("t5_lock_lost_latency", k, 3);
        check("t5_ready_same_edge", ready, 0);
        check("t5_sys_rst_same_edge", sys_rst, 1);
        lp = 0;
        n  = 0;
        for (int i = 0; i < 12; i++) begin
            lp += int'(lock_lost);
            n  += int'(pll_rst);
            @(negedge refclk);
        end
        check("t5_lock_lost_width", lp, 1);
        check("t5_pll_rst_pulse", n, 4);

        // 2: lock glitch during qualification
        pll_locked = 1'b1;
        r = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge refclk);
            r += int'(ready);
        end
        pll_locked = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge refclk);
            r += int'(ready);
        end
        check("t2_back_to_wait", state_o, 1);
        check("t2_no_ready", r, 0);
        pll_locked = 1'b1;
        wait_ready(k);
        check("t2_ready_latency", k, 11);

        // 3: timeouts then failure
        pll_locked = 1'b0;
        for (int i = 1; i <= 130; i++) begin
            @(negedge refclk);
            pr[i] = pll_rst;
            rc[i] = int'(retry_cnt);
            fl[i] = fail;
        end
        check("t3_first_pulse_end", int'(pr[6]) * 2 + int'(pr[7]), 2);
        check("t3_retry1_edge", rc[38] * 10 + rc[39], 1);
        check("t3_repulse1", int'(pr[38]) * 2 + int'(pr[39]), 1);
        check("t3_pulse2_end", int'(pr[42]) * 2 + int'(pr[43]), 2);
        c = 0;
        for (int i = 43; i <= 74; i++) if (!pr[i]) c++;
        check("t3_wait_len", c, 32);
        check("t3_retry2_edge", rc[74] * 10 + rc[75], 12);
        check("t3_fail_edge", int'(fl[110]) * 2 + int'(fl[111]), 1);
        check("t3_retry_at_fail", rc[111], 3);
        c = 0;
        for (int i = 111; i <= 130; i++) if (pr[i]) c++;
        check("t3_pll_rst_held", c, 20);

        // 4: recovery from FAIL
        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
        check("t4_fail_clear", fail, 0);
        check("t4_retry_clear", retry_cnt, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            n += int'(pll_rst);
            @(negedge refclk);
        end
        check("t4_pll_rst_pulse", n, 4);
        pll_locked = 1'b1;
        wait_ready(k);
        check("t4_ready_latency", k, 11);

        // 6a: relock from RUN, then rst in the middle of qualification
        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
        check("t6_relock_no_pulse", lock_lost, 0);
        check("t6_relock_state", state_o, 0);
        repeat (7) @(negedge refclk);
        check("t6_in_stable", state_o, 2);
        rst = 1'b1;
        @(negedge refclk);
        check_reset_values("t6_midreset");
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        wait_ready(k);
        check("t6_ready_after_reset", k, 13);

        // 6b: relock_req colliding with lock loss in RUN
        pll_locked = 1'b0;
        repeat (2) @(negedge refclk);
        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
        check("t6_collide_pulse", lock_lost, 1);
        check("t6_collide_state", state_o, 0);
        lp = 0;
        for (int i = 0; i < 10; i++) begin
            lp += int'(lock_lost);
            @(negedge refclk);
        end
        check("t6_collide_pulse_count", lp, 1);

        repeat (5) @(negedge refclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
